// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//
// Front-end driver for the 4-bit ALU. Raw switches and two active-low
// pushbuttons are synchronised. Each button is debounced and reduced to a
// one-cycle press pulse. The user steps through operand A, operand B and
// the mode code. After the ALU has had time to settle, its flags are
// sampled and the result is held on the outputs until the next enter.
//
// Ports
//   clk          system clock (single domain)
//   rst_n        asynchronous active-low reset
//   sw[3:0]      operand/mode switches, asynchronous to clk
//   key_enter_n  raw enter button, active-low
//   key_clear_n  raw clear button, active-low
//   alu_neg      ALU negative flag
//   alu_cero     ALU zero flag
//   alu_carry    ALU carry flag
//   in1[3:0]     operand A to the ALU
//   in2[3:0]     operand B to the ALU
//   mode[3:0]    operation code to the ALU
//   op_valid     high while a finished operation is shown
//   flags[3:0]   {err, carry, cero, neg} sampled at the end of RUN
//   state_seg    active-low seven-segment step indicator
module alu_operand_sequencer #(
  parameter int DEB_CYCLES    = 500000,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       key_enter_n,
  input  logic       key_clear_n,
  input  logic       alu_neg,
  input  logic       alu_cero,
  input  logic       alu_carry,
  output logic [3:0] in1,
  output logic [3:0] in2,
  output logic [3:0] mode,
  output logic       op_valid,
  output logic [3:0] flags,
  output logic [6:0] state_seg
);

  localparam int              DEB_W       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    ENTER_M,
    RUN,
    SHOW
  } state_t;

  // Key index 0 is enter, index 1 is clear.
  logic [3:0] sw_meta_q,  sw_meta_d;
  logic [3:0] sw_sync_q,  sw_sync_d;
  logic [1:0] key_meta_q, key_meta_d;
  logic [1:0] key_sync_q, key_sync_d;

  logic [DEB_W-1:0] deb_cnt_q [2];
  logic [DEB_W-1:0] deb_cnt_d [2];
  logic [1:0]       deb_lvl_q, deb_lvl_d;
  logic [1:0]       press_q,   press_d;

  state_t     state_q,    state_d;
  logic [3:0] in1_q,      in1_d;
  logic [3:0] in2_q,      in2_d;
  logic [3:0] mode_q,     mode_d;
  logic [3:0] flags_q,    flags_d;
  logic       op_valid_q, op_valid_d;
  logic [3:0] settle_q,   settle_d;
  logic [6:0] seg_q,      seg_d;

  logic enter_p;
  logic clear_p;
  logic mode_err;

  assign enter_p = press_q[0];
  assign clear_p = press_q[1];

  // Two-flop synchronisers for the asynchronous switch and button inputs.
  always_comb begin
    sw_meta_d  = sw;
    sw_sync_d  = sw_meta_q;
    key_meta_d = {key_clear_n, key_enter_n};
    key_sync_d = key_meta_q;
  end

  // Per-key debounce. The counter only runs while the synchronised level
  // disagrees with the accepted level. A press pulse is produced only when
  // the accepted level falls from released to pressed.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      deb_cnt_d[k] = '0;
      deb_lvl_d[k] = deb_lvl_q[k];
      press_d[k]   = 1'b0;
      if (key_sync_q[k] != deb_lvl_q[k]) begin
        if (deb_cnt_q[k] == DEB_LAST) begin
          deb_lvl_d[k] = key_sync_q[k];
          press_d[k]   = deb_lvl_q[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Only four mode codes are implemented by the ALU.
  always_comb begin
    case (mode_q)
      4'h0, 4'h1, 4'h3, 4'h4: mode_err = 1'b0;
      default:                mode_err = 1'b1;
    endcase
  end

  // Step sequencer. Clear takes priority over everything, including an
  // enter pulse in the same cycle. RUN ignores enter and only waits out
  // the settle time before sampling the ALU flags.
  always_comb begin
    state_d    = state_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    mode_d     = mode_q;
    flags_d    = flags_q;
    op_valid_d = op_valid_q;
    settle_d   = settle_q;
    if (clear_p) begin
      state_d    = ENTER_A;
      in1_d      = 4'h0;
      in2_d      = 4'h0;
      mode_d     = 4'h0;
      flags_d    = 4'h0;
      op_valid_d = 1'b0;
      settle_d   = 4'h0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (enter_p) begin
            in1_d   = sw_sync_q;
            state_d = ENTER_B;
          end
        end
        ENTER_B: begin
          if (enter_p) begin
            in2_d   = sw_sync_q;
            state_d = ENTER_M;
          end
        end
        ENTER_M: begin
          if (enter_p) begin
            mode_d   = sw_sync_q;
            settle_d = 4'h0;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (settle_q == SETTLE_LAST) begin
            flags_d    = {mode_err, alu_carry, alu_cero, alu_neg};
            op_valid_d = 1'b1;
            state_d    = SHOW;
          end else begin
            settle_d = settle_q + 4'h1;
          end
        end
        SHOW: begin
          if (enter_p) begin
            op_valid_d = 1'b0;
            state_d    = ENTER_A;
          end
        end
        default: state_d = ENTER_A;
      endcase
    end
  end

  // The indicator is decoded from the next state so that it is registered
  // alongside the state itself; the error glyph uses the flag being loaded.
  always_comb begin
    case (state_d)
      ENTER_A: seg_d = SEG_A;
      ENTER_B: seg_d = SEG_B;
      ENTER_M: seg_d = SEG_D;
      RUN:     seg_d = SEG_DASH;
      SHOW:    seg_d = flags_d[3] ? SEG_E : SEG_BLANK;
      default: seg_d = SEG_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q    <= 4'h0;
      sw_sync_q    <= 4'h0;
      key_meta_q   <= 2'b11;
      key_sync_q   <= 2'b11;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
      deb_lvl_q    <= 2'b11;
      press_q      <= 2'b00;
      state_q      <= ENTER_A;
      in1_q        <= 4'h0;
      in2_q        <= 4'h0;
      mode_q       <= 4'h0;
      flags_q      <= 4'h0;
      op_valid_q   <= 1'b0;
      settle_q     <= 4'h0;
      seg_q        <= SEG_A;
    end else begin
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      key_meta_q   <= key_meta_d;
      key_sync_q   <= key_sync_d;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
      deb_lvl_q    <= deb_lvl_d;
      press_q      <= press_d;
      state_q      <= state_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      mode_q       <= mode_d;
      flags_q      <= flags_d;
      op_valid_q   <= op_valid_d;
      settle_q     <= settle_d;
      seg_q        <= seg_d;
    end
  end

  assign in1       = in1_q;
  assign in2       = in2_q;
  assign mode      = mode_q;
  assign flags     = flags_q;
  assign op_valid  = op_valid_q;
  assign state_seg = seg_q;

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Front-end driver for the 4-bit ALU; it is the producing end of the ALU's in1/in2/mode interface.
- Takes raw board switches and two pushbuttons, and debounces the buttons.
- Walks the user through entering operand A, operand B and the mode code, then presents a stable operation to the ALU.
- Captures the ALU's neg/cero/carry flags once the result has settled and shows progress on a dedicated seven-segment digit.

Parameters:
- DEB_CYCLES, 500000, consecutive stable cycles required before a button level change is accepted (10 ms at 50 MHz); bench uses 4.
- SETTLE_CYCLES, 2, cycles spent in RUN before the ALU flags are sampled; legal range 1..15.

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  4  operand/mode switches, asynchronous to clk.
- key_enter_n  in  1  raw enter pushbutton, active-low.
- key_clear_n  in  1  raw clear pushbutton, active-low.
- alu_neg  in  1  ALU negative flag.
- alu_cero  in  1  ALU zero flag.
- alu_carry  in  1  ALU carry flag.
- in1  out  4  operand A to ALU.
- in2  out  4  operand B to ALU.
- mode  out  4  operation code to ALU.
- op_valid  out  1  high while a completed operation with sampled flags is being shown.
- flags  out  4  {err, carry, cero, neg} sampled in RUN.
- state_seg  out  7  active-low segment pattern for the step indicator.

Behaviour:
- Reset: while rst_n=0, in1=in2=mode=0, flags=0, op_valid=0, state=ENTER_A, state_seg=7'b0001000. Reset takes effect asynchronously and is legal mid-operation; all debounce state is cleared.
- Synchronisers: sw, key_enter_n and key_clear_n each pass through 2 flops before use.
- Debounce:
  - Each key has its own counter.
  - The counter clears whenever the synchronised level equals the debounced level.
  - Otherwise the counter increments; when it reaches DEB_CYCLES-1 the debounced level flips and the counter clears.
  - Debounced level resets to released (1).
  - A press pulse (1 cycle) fires on the debounced 1->0 transition only. Releases produce nothing.
  - Glitches shorter than DEB_CYCLES produce no pulse.
  - Press latency from raw edge to pulse: DEB_CYCLES+2 to DEB_CYCLES+3 cycles.
- States and state_seg:
  - ENTER_A: 7'b0001000 ('A').
  - ENTER_B: 7'b0000011 ('b').
  - ENTER_M: 7'b0100001 ('d').
  - RUN: 7'b0111111 ('-').
  - SHOW: 7'b1111111 if err=0, 7'b0000110 ('E') if err=1.
- Transitions on enter pulse:
  - ENTER_A: in1<=sw_sync, go ENTER_B.
  - ENTER_B: in2<=sw_sync, go ENTER_M.
  - ENTER_M: mode<=sw_sync, go RUN, settle counter<=0.
  - SHOW: op_valid<=0, go ENTER_A. in1/in2/mode keep their old values until each is overwritten.
  - RUN: enter pulses are ignored.
- RUN:
  - The settle counter increments each cycle.
  - On the cycle it equals SETTLE_CYCLES-1: flags<={err, alu_carry, alu_cero, alu_neg}, op_valid<=1, go SHOW.
  - err=1 iff mode is not one of 4'b0000, 4'b0001, 4'b0011, 4'b0100.
- op_valid is high exactly while in SHOW.
- in1/in2/mode never change while in RUN or SHOW.
- Clear pulse, from any state:
  - in1=in2=mode=0, flags=0, op_valid=0, go ENTER_A on the next edge.
  - Clear and enter in the same cycle: clear wins and the enter is discarded.
- Clear and enter are fully independent. Holding one key does not block debounce of the other.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset (DEB_CYCLES=4, SETTLE_CYCLES=2) -> all outputs 0, state_seg=7'b0001000. Assert rst_n=0 during RUN -> immediate return to reset values.
- Full sequence:
  - sw=4'h5, press enter -> in1=5, state_seg='b'.
  - sw=4'h3, press enter -> in2=3.
  - sw=4'h0, press enter -> mode=0.
  - Drive alu_carry=0, alu_cero=0, alu_neg=0 -> op_valid rises exactly 2 cycles after entering RUN, flags=4'b0000, state_seg=7'b1111111.
- Error mode:
  - Enter A=2, B=1, mode=4'h7 with alu flags {carry=1, cero=0, neg=1} -> flags=4'b1101, state_seg=7'b0000110.
  - Press enter -> op_valid=0, ENTER_A, in1 still 2.
- Bounce: pulse key_enter_n low for 3 cycles, 5 times at 2-cycle spacing, then hold low 10 cycles -> exactly one enter pulse and one state advance; holding for 100 cycles adds no further advance.
- Simultaneous keys: in ENTER_M, key_enter_n and key_clear_n fall on the same edge -> state ENTER_A, mode=0, in1=in2=0, no RUN entry.
- Ignored input in RUN: with SETTLE_CYCLES=8, press enter during RUN -> no effect; SHOW reached 8 cycles after RUN entry with in1/in2/mode unchanged.
